// File: rtl/exec_muldiv_sequencer.sv
// Multi-cycle unsigned MUL/DIVU/MODU sequencer beside the Execute ALU.
// One bit per clock (negedge), stalls the pipeline while running, strobes the result for one cycle.
module exec_muldiv_sequencer #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 5
) (
    input  logic             I_CLOCK,
    input  logic             I_RESET,
    input  logic             I_Start,
    input  logic [1:0]       I_Op,
    input  logic [WIDTH-1:0] I_SrcA,
    input  logic [WIDTH-1:0] I_SrcB,
    input  logic [3:0]       I_DestRegIdx,
    input  logic             I_Flush,
    output logic             O_Busy,
    output logic             O_Stall,
    output logic             O_Done,
    output logic [WIDTH-1:0] O_Result,
    output logic [WIDTH-1:0] O_ResultHi,
    output logic [3:0]       O_DestRegIdx,
    output logic             O_DivByZero
);

    // StShort is the single non-busy cycle of the divide-by-zero and reserved-op paths.
    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StShort,
        StDone
    } state_e;

    localparam logic [1:0]       OpMul    = 2'b00;
    localparam logic [1:0]       OpDivu   = 2'b01;
    localparam logic [1:0]       OpModu   = 2'b10;
    localparam logic [1:0]       OpRsv    = 2'b11;
    localparam logic [CNT_W-1:0] LastIter = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic [3:0]       dest_q, dest_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d;
    logic [3:0]       dest_out_q, dest_out_d;
    logic             dbz_q, dbz_d;

    // acc holds the product high half (MUL) or partial remainder (DIV);
    // lo holds the multiplier being shifted out or the dividend/quotient.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_trial;
    logic [WIDTH-1:0] acc_step;
    logic [WIDTH-1:0] lo_step;

    always_comb begin
        mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {acc_q, lo_q[WIDTH-1]};
        div_trial = div_shift - {1'b0, opnd_q};
        acc_step  = acc_q;
        lo_step   = lo_q;
        if (op_q == OpMul) begin
            acc_step = mul_sum[WIDTH:1];
            lo_step  = {mul_sum[0], lo_q[WIDTH-1:1]};
        end else if (!div_trial[WIDTH]) begin
            // Non-negative trial: remainder fits in WIDTH bits since it is below the divisor.
            acc_step = div_trial[WIDTH-1:0];
            lo_step  = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
            acc_step = div_shift[WIDTH-1:0];
            lo_step  = {lo_q[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        dest_d     = dest_q;
        opnd_d     = opnd_q;
        acc_d      = acc_q;
        lo_d       = lo_q;
        res_d      = res_q;
        res_hi_d   = res_hi_q;
        dest_out_d = dest_out_q;
        dbz_d      = dbz_q;

        if (I_Flush) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    state_d = StIdle;
                    if (I_Start) begin
                        op_d   = I_Op;
                        dest_d = I_DestRegIdx;
                        cnt_d  = '0;
                        acc_d  = '0;
                        case (I_Op)
                            OpMul: begin
                                opnd_d  = I_SrcA;
                                lo_d    = I_SrcB;
                                state_d = StRun;
                            end
                            OpDivu, OpModu: begin
                                opnd_d = I_SrcB;
                                if (I_SrcB == '0) begin
                                    // Pre-load the fixed divide-by-zero answer into lo.
                                    lo_d    = (I_Op == OpDivu) ? '1 : I_SrcA;
                                    state_d = StShort;
                                end else begin
                                    lo_d    = I_SrcA;
                                    state_d = StRun;
                                end
                            end
                            default: begin
                                opnd_d  = I_SrcB;
                                lo_d    = '0;
                                state_d = StShort;
                            end
                        endcase
                    end
                end
                StRun: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    acc_d = acc_step;
                    lo_d  = lo_step;
                    if (cnt_q == LastIter) begin
                        state_d    = StDone;
                        dest_out_d = dest_q;
                        dbz_d      = 1'b0;
                        case (op_q)
                            OpMul: begin
                                res_d    = lo_step;
                                res_hi_d = acc_step;
                            end
                            OpModu: begin
                                res_d    = acc_step;
                                res_hi_d = '0;
                            end
                            default: begin
                                res_d    = lo_step;
                                res_hi_d = '0;
                            end
                        endcase
                    end
                end
                StShort: begin
                    state_d    = StDone;
                    res_d      = lo_q;
                    res_hi_d   = '0;
                    dbz_d      = (op_q != OpRsv);
                    dest_out_d = dest_q;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(negedge I_CLOCK) begin
        if (I_RESET) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            op_q       <= '0;
            dest_q     <= '0;
            opnd_q     <= '0;
            acc_q      <= '0;
            lo_q       <= '0;
            res_q      <= '0;
            res_hi_q   <= '0;
            dest_out_q <= '0;
            dbz_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            dest_q     <= dest_d;
            opnd_q     <= opnd_d;
            acc_q      <= acc_d;
            lo_q       <= lo_d;
            res_q      <= res_d;
            res_hi_q   <= res_hi_d;
            dest_out_q <= dest_out_d;
            dbz_q      <= dbz_d;
        end
    end

    assign O_Busy       = (state_q == StRun);
    assign O_Stall      = (state_q == StRun);
    assign O_Done       = (state_q == StDone);
    assign O_Result     = res_q;
    assign O_ResultHi   = res_hi_q;
    assign O_DestRegIdx = dest_out_q;
    assign O_DivByZero  = dbz_q;

endmodule

// File: tb/tb_exec_muldiv_sequencer.sv
// Self-checking bench for exec_muldiv_sequencer: directed scenarios plus random ops
// checked against a plain-arithmetic reference model.
module tb_exec_muldiv_sequencer;

    localparam int W = 16;

    logic         I_CLOCK = 1'b0;
    logic         I_RESET = 1'b1;
    logic         I_Start = 1'b0;
    logic [1:0]   I_Op = 2'b00;
    logic [W-1:0] I_SrcA = '0;
    logic [W-1:0] I_SrcB = '0;
    logic [3:0]   I_DestRegIdx = '0;
    logic         I_Flush = 1'b0;
    logic         O_Busy;
    logic         O_Stall;
    logic         O_Done;
    logic [W-1:0] O_Result;
    logic [W-1:0] O_ResultHi;
    logic [3:0]   O_DestRegIdx;
    logic         O_DivByZero;

    int n_cmp = 0;
    int n_fail = 0;

    exec_muldiv_sequencer #(.WIDTH(16), .CNT_W(5)) dut (
        .I_CLOCK      (I_CLOCK),
        .I_RESET      (I_RESET),
        .I_Start      (I_Start),
        .I_Op         (I_Op),
        .I_SrcA       (I_SrcA),
        .I_SrcB       (I_SrcB),
        .I_DestRegIdx (I_DestRegIdx),
        .I_Flush      (I_Flush),
        .O_Busy       (O_Busy),
        .O_Stall      (O_Stall),
        .O_Done       (O_Done),
        .O_Result     (O_Result),
        .O_ResultHi   (O_ResultHi),
        .O_DestRegIdx (O_DestRegIdx),
        .O_DivByZero  (O_DivByZero)
    );

    always #5 I_CLOCK = ~I_CLOCK;

    task automatic tick();
        @(negedge I_CLOCK);
        #1;
    endtask

    // Present a request for one active edge, then scramble the inputs so latching is exercised.
    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [3:0] d);
        I_Start = 1'b1; I_Op = op; I_SrcA = a; I_SrcB = b; I_DestRegIdx = d;
        tick();
        I_Start = 1'b0;
        I_Op = 2'($urandom); I_SrcA = W'($urandom); I_SrcB = W'($urandom);
        I_DestRegIdx = 4'($urandom);
    endtask

    task automatic wait_done(output int edges, output int busy, output int stall);
        edges = 0; busy = 0; stall = 0;
        while (O_Done !== 1'b1 && edges < 200) begin
            if (O_Busy === 1'b1) busy++;
            if (O_Stall === 1'b1) stall++;
            tick();
            edges++;
        end
    endtask

    function automatic void model(input logic [1:0] op, input logic [W-1:0] a,
                                  input logic [W-1:0] b, output logic [W-1:0] lo,
                                  output logic [W-1:0] hi, output logic z, output int lat);
        logic [2*W-1:0] p;
        lo = '0; hi = '0; z = 1'b0; lat = W;
        case (op)
            2'd0: begin p = a * b; hi = p[2*W-1:W]; lo = p[W-1:0]; end
            2'd1: if (b == 0) begin lo = '1; z = 1'b1; lat = 1; end else lo = a / b;
            2'd2: if (b == 0) begin lo = a; z = 1'b1; lat = 1; end else lo = a % b;
            default: lat = 1;
        endcase
    endfunction

    task automatic test_reset();
        I_RESET = 1'b1;
        tick(); tick();
        I_RESET = 1'b0;
        n_cmp++;
        if ({O_Busy, O_Stall, O_Done, O_DivByZero} !== 4'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b want 0000",
                               {O_Busy, O_Stall, O_Done, O_DivByZero});
        end
        n_cmp++;
        if ({O_Result, O_ResultHi, O_DestRegIdx} !== '0) begin
            n_fail++; $display("FAIL reset_data: got %h %h %h want 0", O_Result, O_ResultHi,
                               O_DestRegIdx);
        end
    endtask

    task automatic test_mul_basic();
        int e, b, s;
        issue(2'b00, 16'h0007, 16'h0009, 4'd3);
        wait_done(e, b, s);
        n_cmp++;
        if (s !== 16) begin n_fail++; $display("FAIL mul_stall_cycles: got %0d want 16", s); end
        n_cmp++;
        if (b !== 16) begin n_fail++; $display("FAIL mul_busy_cycles: got %0d want 16", b); end
        n_cmp++;
        if (e !== 16) begin n_fail++; $display("FAIL mul_latency: got %0d want 16", e); end
        n_cmp++;
        if (O_Result !== 16'h003F) begin
            n_fail++; $display("FAIL mul_result: got %h want 003f", O_Result);
        end
        n_cmp++;
        if (O_ResultHi !== 16'h0000) begin
            n_fail++; $display("FAIL mul_result_hi: got %h want 0000", O_ResultHi);
        end
        n_cmp++;
        if (O_DestRegIdx !== 4'd3) begin
            n_fail++; $display("FAIL mul_dest: got %0d want 3", O_DestRegIdx);
        end
        tick();
        n_cmp++;
        if (O_Done !== 1'b0) begin n_fail++; $display("FAIL mul_done_one_cycle: got %b want 0", O_Done); end
        n_cmp++;
        if (O_Result !== 16'h003F) begin
            n_fail++; $display("FAIL mul_result_hold: got %h want 003f", O_Result);
        end
    endtask

    task automatic test_back_to_back();
        int e, b, s;
        issue(2'b00, 16'hFFFF, 16'hFFFF, 4'd5);
        wait_done(e, b, s);
        n_cmp++;
        if ({O_ResultHi, O_Result} !== 32'hFFFE_0001) begin
            n_fail++; $display("FAIL b2b_mul_ffff: got %h%h want fffe0001", O_ResultHi, O_Result);
        end
        issue(2'b01, 16'd100, 16'd7, 4'd6);
        n_cmp++;
        if ({O_Done, O_Busy} !== 2'b01) begin
            n_fail++; $display("FAIL b2b_no_bubble: got done,busy=%b want 01", {O_Done, O_Busy});
        end
        wait_done(e, b, s);
        n_cmp++;
        if (e !== 16) begin n_fail++; $display("FAIL b2b_latency: got %0d want 16", e); end
        n_cmp++;
        if ({O_Result, O_ResultHi, O_DestRegIdx} !== {16'd14, 16'd0, 4'd6}) begin
            n_fail++; $display("FAIL b2b_divu: got %0d hi %h dest %0d want 14 hi 0 dest 6",
                               O_Result, O_ResultHi, O_DestRegIdx);
        end
        issue(2'b10, 16'd100, 16'd7, 4'd7);
        wait_done(e, b, s);
        n_cmp++;
        if ({O_Result, O_DestRegIdx} !== {16'd2, 4'd7}) begin
            n_fail++; $display("FAIL b2b_modu: got %0d dest %0d want 2 dest 7", O_Result,
                               O_DestRegIdx);
        end
        tick();
    endtask

    task automatic test_div_zero();
        int e, b, s;
        issue(2'b01, 16'd5, 16'd0, 4'd9);
        n_cmp++;
        if ({O_Busy, O_Done} !== 2'b00) begin
            n_fail++; $display("FAIL dz_first_cycle: got busy,done=%b want 00", {O_Busy, O_Done});
        end
        wait_done(e, b, s);
        n_cmp++;
        if (e !== 1 || b !== 0) begin
            n_fail++; $display("FAIL dz_latency: got %0d busy %0d want 1 busy 0", e, b);
        end
        n_cmp++;
        if ({O_Result, O_ResultHi, O_DivByZero} !== {16'hFFFF, 16'h0, 1'b1}) begin
            n_fail++; $display("FAIL dz_divu: got %h %h dbz %b want ffff 0000 dbz 1", O_Result,
                               O_ResultHi, O_DivByZero);
        end
        tick();
        n_cmp++;
        if ({O_Done, O_DivByZero} !== 2'b01) begin
            n_fail++; $display("FAIL dz_hold: got done,dbz=%b want 01", {O_Done, O_DivByZero});
        end
        issue(2'b10, 16'd5, 16'd0, 4'd2);
        wait_done(e, b, s);
        n_cmp++;
        if ({O_Result, O_DivByZero, O_DestRegIdx} !== {16'd5, 1'b1, 4'd2}) begin
            n_fail++; $display("FAIL dz_modu: got %0d dbz %b dest %0d want 5 dbz 1 dest 2",
                               O_Result, O_DivByZero, O_DestRegIdx);
        end
        issue(2'b11, 16'h1234, 16'h5678, 4'd11);
        wait_done(e, b, s);
        n_cmp++;
        if ({O_Result, O_ResultHi, O_DivByZero} !== 33'b0 || e !== 1) begin
            n_fail++; $display("FAIL reserved_op: got %h %h dbz %b lat %0d want 0 0 dbz 0 lat 1",
                               O_Result, O_ResultHi, O_DivByZero, e);
        end
        tick();
    endtask

    task automatic test_start_ignored();
        int e, b, s, dones;
        issue(2'b00, 16'h1234, 16'h0056, 4'd4);
        repeat (4) tick();
        I_Start = 1'b1; I_Op = 2'b01; I_SrcA = 16'h9999; I_SrcB = 16'h0003; I_DestRegIdx = 4'd12;
        tick();
        I_Start = 1'b0;
        wait_done(e, b, s);
        n_cmp++;
        if (e + 5 !== 16) begin n_fail++; $display("FAIL ign_latency: got %0d want 16", e + 5); end
        n_cmp++;
        if ({O_ResultHi, O_Result, O_DestRegIdx} !== {32'h1234 * 32'h56, 4'd4}) begin
            n_fail++; $display("FAIL ign_result: got %h%h dest %0d want %h dest 4", O_ResultHi,
                               O_Result, O_DestRegIdx, 32'h1234 * 32'h56);
        end
        dones = 0;
        repeat (20) begin tick(); if (O_Done === 1'b1) dones++; end
        n_cmp++;
        if (dones !== 0) begin n_fail++; $display("FAIL ign_extra_done: got %0d want 0", dones); end
    endtask

    task automatic test_flush();
        int e, b, s, dones;
        issue(2'b01, 16'hBEEF, 16'h0013, 4'd8);
        repeat (7) tick();
        I_Flush = 1'b1;
        tick();
        I_Flush = 1'b0;
        n_cmp++;
        if ({O_Busy, O_Stall, O_Done} !== 3'b000) begin
            n_fail++; $display("FAIL flush_state: got busy,stall,done=%b want 000",
                               {O_Busy, O_Stall, O_Done});
        end
        dones = 0;
        repeat (20) begin tick(); if (O_Done === 1'b1) dones++; end
        n_cmp++;
        if (dones !== 0) begin n_fail++; $display("FAIL flush_no_done: got %0d want 0", dones); end
        issue(2'b00, 16'd3, 16'd4, 4'd1);
        wait_done(e, b, s);
        n_cmp++;
        if ({O_Result, O_DestRegIdx} !== {16'd12, 4'd1} || e !== 16) begin
            n_fail++; $display("FAIL flush_next_mul: got %0d dest %0d lat %0d want 12 dest 1 lat 16",
                               O_Result, O_DestRegIdx, e);
        end
        tick();
    endtask

    task automatic test_reset_midop();
        int e, b, s;
        issue(2'b00, 16'hABCD, 16'h1111, 4'hF);
        repeat (3) tick();
        I_RESET = 1'b1; I_Flush = 1'b1; I_Start = 1'b1; I_Op = 2'b00;
        tick();
        I_RESET = 1'b0; I_Flush = 1'b0; I_Start = 1'b0;
        n_cmp++;
        if ({O_Busy, O_Stall, O_Done, O_DivByZero, O_Result, O_ResultHi, O_DestRegIdx} !== '0)
        begin
            n_fail++; $display("FAIL midop_reset: got flags %b data %h %h %h want all 0",
                               {O_Busy, O_Stall, O_Done, O_DivByZero}, O_Result, O_ResultHi,
                               O_DestRegIdx);
        end
        tick();
        n_cmp++;
        if ({O_Busy, O_Done} !== 2'b00) begin
            n_fail++; $display("FAIL midop_idle: got busy,done=%b want 00", {O_Busy, O_Done});
        end
        issue(2'b10, 16'd1000, 16'd33, 4'd10);
        wait_done(e, b, s);
        n_cmp++;
        if ({O_Result, O_DestRegIdx} !== {16'd10, 4'd10} || e !== 16) begin
            n_fail++; $display("FAIL midop_next: got %0d dest %0d lat %0d want 10 dest 10 lat 16",
                               O_Result, O_DestRegIdx, e);
        end
        tick();
    endtask

    task automatic test_random();
        int e, b, s, lat;
        logic [1:0]   op;
        logic [W-1:0] a, bb, lo, hi;
        logic [3:0]   d;
        logic         z;
        for (int i = 0; i < 30; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = W'($urandom);
            bb = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom >> $urandom_range(0, 15));
            d  = 4'($urandom);
            model(op, a, bb, lo, hi, z, lat);
            issue(op, a, bb, d);
            wait_done(e, b, s);
            n_cmp++;
            if ({O_Result, O_ResultHi, O_DestRegIdx, O_DivByZero} !== {lo, hi, d, z}) begin
                n_fail++; $display("FAIL rand_%0d op %0d %h,%h: got %h %h dest %0d dbz %b want %h %h dest %0d dbz %b",
                                   i, op, a, bb, O_Result, O_ResultHi, O_DestRegIdx, O_DivByZero,
                                   lo, hi, d, z);
            end
            n_cmp++;
            if (e !== lat || b !== ((lat == 1) ? 0 : W)) begin
                n_fail++; $display("FAIL rand_timing_%0d: got lat %0d busy %0d want lat %0d", i,
                                   e, b, lat);
            end
            if ($urandom_range(0, 1) == 1) tick();
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_mul_basic();
        test_back_to_back();
        test_div_zero();
        test_start_ignored();
        test_flush();
        test_reset_midop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/exec_muldiv_sequencer.md
Name: exec_muldiv_sequencer

Overview:
Multi-cycle multiply/divide sequencer beside the single-cycle Execute ALU. Accepts one MUL/DIVU/MODU request from decode, iterates one bit per clock, and asserts a pipeline stall while busy. It then presents the result and destination register index to the memory stage for one cycle. Lets the ALU stay single-cycle while the pipeline supports long-latency arithmetic.

Parameters:
WIDTH, 16, operand/result width (matches REG_WIDTH)
CNT_W, 5, iteration counter width; must hold WIDTH

Ports:
I_CLOCK  in  1  pipeline clock; all state updates on negedge, same as the other pipeline stages
I_RESET  in  1  synchronous active-high reset
I_Start  in  1  request valid; sampled only in IDLE or DONE
I_Op  in  2  00 MUL, 01 DIVU (quotient), 10 MODU (remainder), 11 reserved
I_SrcA  in  WIDTH  multiplicand / dividend
I_SrcB  in  WIDTH  multiplier / divisor
I_DestRegIdx  in  4  destination register, carried through
I_Flush  in  1  abort in-flight operation (branch mispredict)
O_Busy  out  1  high in RUN; upstream must hold its request
O_Stall  out  1  equals O_Busy; drives fetch/decode stall
O_Done  out  1  one-cycle result-valid strobe
O_Result  out  WIDTH  MUL low half, quotient, or remainder
O_ResultHi  out  WIDTH  MUL high half; 0 for DIVU/MODU
O_DestRegIdx  out  4  latched destination
O_DivByZero  out  1  valid with O_Done

Behaviour:
- States: IDLE, RUN, DONE. All outputs are registered or decoded from state only; no combinational input-to-output paths.
- Reset (I_RESET=1 at a negedge): state=IDLE, counter=0; O_Busy/O_Stall/O_Done/O_DivByZero=0; O_Result/O_ResultHi=0; O_DestRegIdx=0. Reset overrides all other inputs, including I_Flush and I_Start.
- IDLE/DONE with I_Start=1: latch operands, op, and dest; counter=0.
  - Op 00/01/10 with nonzero divisor (or MUL): go to RUN.
  - Divide or modulo with I_SrcB=0: go to DONE next edge, 1-cycle latency. Quotient=all ones, remainder=I_SrcA, O_DivByZero=1.
  - Op 11: go to DONE next edge with O_Result=0, O_ResultHi=0, O_DivByZero=0.
- IDLE/DONE with I_Start=0: go to IDLE. The DONE-to-RUN path gives back-to-back issue with no bubble.
- RUN: one iteration per edge; counter increments.
  - MUL: shift-add, 2*WIDTH-bit product register, LSB-first over the multiplier.
  - DIVU/MODU: restoring division, MSB-first. Partial remainder is WIDTH+1 bits; a trial subtract sets the quotient bit when non-negative.
  - On the edge completing iteration WIDTH-1: go to DONE, load output registers.
- Latency: start accepted at edge k gives O_Done=1 during the cycle after edge k+WIDTH (16 for default). The divide-by-zero and reserved-op paths give O_Done=1 after edge k+1.
- O_Done is high exactly while in DONE (one cycle unless restarted, which still drops it next cycle unless that op also completes). O_Result/O_ResultHi/O_DestRegIdx/O_DivByZero hold their last values outside DONE.
- I_Start while in RUN: ignored, no latch, no state change.
- I_Flush=1 (no reset): any state goes to IDLE, O_Done=0, counter cleared; a simultaneous I_Start is dropped. Data outputs are not cleared.
- Arithmetic is unsigned and no overflow is possible: MUL is a full 2*WIDTH product, DIVU quotient is at most WIDTH bits.
- O_Busy=O_Stall=1 for exactly WIDTH cycles per non-shortcut operation.

Test Plan:
- MUL 0x0007*0x0009, dest 3: O_Stall high 16 cycles; then O_Done=1, O_Result=0x003F, O_ResultHi=0, O_DestRegIdx=3.
- MUL 0xFFFF*0xFFFF: O_ResultHi=0xFFFE, O_Result=0x0001. Then back-to-back DIVU 100/7 issued during DONE: second O_Done exactly 16 edges later with O_Result=14. MODU 100/7 gives 2.
- DIVU 5/0: O_Done one cycle after accept, O_Result=0xFFFF, O_DivByZero=1, O_Busy never high. MODU 5/0 gives O_Result=5.
- I_Start pulsed with new operands at cycle 5 of a running MUL: result unchanged from the original operands, no extra O_Done.
- I_Flush at cycle 8 of DIVU: O_Busy drops next edge, no O_Done. A new MUL 3*4 afterwards returns 12.
- I_RESET at cycle 4 of MUL, together with I_Flush and I_Start: all outputs 0, state IDLE. The next request completes normally.
